// File: rtl/i2s_pkg.sv
// Shared I2S definitions: alignment FSM states and the default sample width.
package i2s_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        StUnlocked,
        StLeft,
        StRight
    } i2s_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input with rise/fall pulses
// detected against a third register.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], din};
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~sync_q[2];
    assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/i2s_target_transmitter.sv
// I2S target transmitter: aligns to external sclk/ws and shifts buffered
// stereo pairs out MSB first, one sclk after each slot boundary.
module i2s_target_transmitter
    import i2s_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             mclk,
    input  logic             rst,
    input  logic             sclk_in,
    input  logic             ws_in,
    input  logic [WIDTH-1:0] tx_data_l,
    input  logic [WIDTH-1:0] tx_data_r,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             sd_tx,
    output logic             locked,
    output logic             underrun
);

    logic sclk_level, sclk_rise, sclk_fall;
    logic ws_level, ws_rise, ws_fall;
    logic unused_edges;

    sync_edge_detect u_sclk_sync (
        .clk   (mclk),
        .rst   (rst),
        .din   (sclk_in),
        .level (sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    sync_edge_detect u_ws_sync (
        .clk   (mclk),
        .rst   (rst),
        .din   (ws_in),
        .level (ws_level),
        .rise  (ws_rise),
        .fall  (ws_fall)
    );

    assign unused_edges = ^{sclk_level, sclk_rise, ws_rise, ws_fall};

    i2s_state_e       state_q, state_d;
    logic             ws_prev_q, ws_prev_d;
    logic             full_q, full_d;
    logic [WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [WIDTH-1:0] act_r_q, act_r_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             sd_tx_q, sd_tx_d;
    logic             underrun_q, underrun_d;

    logic boundary, left_start, consume, accept;

    assign boundary = sclk_fall && (ws_level != ws_prev_q);

    always_comb begin
        state_d    = state_q;
        left_start = 1'b0;
        unique case (state_q)
            StUnlocked: begin
                if (boundary && !ws_level) begin
                    state_d    = StLeft;
                    left_start = 1'b1;
                end
            end
            // Any boundary advances the slot; wrong polarity never forces a relock.
            StLeft: begin
                if (boundary) state_d = StRight;
            end
            StRight: begin
                if (boundary) begin
                    state_d    = StLeft;
                    left_start = 1'b1;
                end
            end
            default: state_d = StUnlocked;
        endcase
    end

    assign consume  = left_start && full_q;
    // The holding slot frees up in the move cycle, so a waiting pair lands then.
    assign tx_ready = !full_q || consume;
    assign accept   = tx_valid && tx_ready;

    always_comb begin
        ws_prev_d  = ws_prev_q;
        full_d     = full_q;
        hold_l_d   = hold_l_q;
        hold_r_d   = hold_r_q;
        act_r_d    = act_r_q;
        shift_d    = shift_q;
        sd_tx_d    = sd_tx_q;
        underrun_d = left_start && !full_q && (state_q != StUnlocked);

        if (accept) begin
            full_d   = 1'b1;
            hold_l_d = tx_data_l;
            hold_r_d = tx_data_r;
        end else if (consume) begin
            full_d = 1'b0;
        end

        if (sclk_fall) begin
            ws_prev_d = ws_level;
            if (state_q != StUnlocked) begin
                sd_tx_d = shift_q[WIDTH-1];
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
            end
        end

        // New word loads behind the bit just driven: its MSB leaves on the next fall.
        if (left_start) begin
            shift_d = consume ? hold_l_q : '0;
            act_r_d = consume ? hold_r_q : '0;
        end else if (state_q == StLeft && boundary) begin
            shift_d = act_r_q;
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q    <= StUnlocked;
            ws_prev_q  <= 1'b0;
            full_q     <= 1'b0;
            hold_l_q   <= '0;
            hold_r_q   <= '0;
            act_r_q    <= '0;
            shift_q    <= '0;
            sd_tx_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ws_prev_q  <= ws_prev_d;
            full_q     <= full_d;
            hold_l_q   <= hold_l_d;
            hold_r_q   <= hold_r_d;
            act_r_q    <= act_r_d;
            shift_q    <= shift_d;
            sd_tx_q    <= sd_tx_d;
            underrun_q <= underrun_d;
        end
    end

    assign sd_tx    = sd_tx_q;
    assign locked   = (state_q != StUnlocked);
    assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_target_transmitter.sv
// Directed bench for i2s_target_transmitter: drives sclk/ws frames, scores
// the serial stream per slot against a queue of pushed pairs.
module tb_i2s_target_transmitter;

    localparam int  W    = 8;
    localparam time HALF = 40;

    logic         mclk      = 1'b0;
    logic         rst       = 1'b1;
    logic         sclk_in   = 1'b1;
    logic         ws_in     = 1'b0;
    logic         tx_valid  = 1'b0;
    logic [W-1:0] tx_data_l = '0;
    logic [W-1:0] tx_data_r = '0;
    logic         tx_ready, sd_tx, locked, underrun;

    i2s_target_transmitter #(.WIDTH(W)) dut (
        .mclk      (mclk),
        .rst       (rst),
        .sclk_in   (sclk_in),
        .ws_in     (ws_in),
        .tx_data_l (tx_data_l),
        .tx_data_r (tx_data_r),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .sd_tx     (sd_tx),
        .locked    (locked),
        .underrun  (underrun)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] r;
        time          t;
    } pair_t;

    pair_t        exp_q[$];
    time          left_t[$];
    int           n_cmp = 0, n_err = 0;
    int           urun_seen = 0;
    int           st_m = 0;  // 0 unlocked, 1 left, 2 right
    int           slot_idx = 0;
    logic         ws_prev_m = 1'b0, lock_m = 1'b0, close_pending = 1'b0;
    logic [W-1:0] cur_word = '0, next_word = '0, act_r_m = '0;
    logic [63:0]  cap_vec = '0;
    int           cap_cnt = 0;

    always @(posedge mclk) if (underrun === 1'b1) urun_seen <= urun_seen + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bits driven after each fall of the slot, MSB first, then zeros.
    task automatic close_slot(input string tag);
        logic [63:0] e;
        e = '0;
        for (int j = 1; j <= cap_cnt; j++) begin
            if (j <= W) e = {e[62:0], cur_word[W-j]};
            else        e = {e[62:0], 1'b0};
        end
        check(tag, cap_vec, e);
    endtask

    task automatic take_pair(input bit may_underrun);
        pair_t p;
        left_t.push_back($time);
        if (exp_q.size() > 0 && exp_q[0].t <= $time) begin
            p = exp_q.pop_front();
            next_word = p.l;
            act_r_m   = p.r;
        end else begin
            next_word = '0;
            act_r_m   = '0;
        end
    endtask

    // Sample the bit driven after the previous fall, then make one sclk period.
    task automatic fall_edge(input logic w);
        cap_vec = {cap_vec[62:0], sd_tx};
        cap_cnt++;
        if (close_pending) begin
            close_slot($sformatf("slot%0d_bits", slot_idx));
            check($sformatf("slot%0d_locked", slot_idx), 64'(locked), 64'(lock_m));
            close_pending = 1'b0;
            cap_vec  = '0;
            cap_cnt  = 0;
            cur_word = next_word;
            slot_idx++;
        end
        sclk_in = 1'b0;
        ws_in   = w;
        if (w != ws_prev_m) begin
            if (st_m == 0 && w == 1'b0) begin
                st_m = 1; lock_m = 1'b1; take_pair(1'b0); close_pending = 1'b1;
            end else if (st_m == 1) begin
                st_m = 2; next_word = act_r_m; close_pending = 1'b1;
            end else if (st_m == 2) begin
                st_m = 1; take_pair(1'b1); close_pending = 1'b1;
            end
        end
        ws_prev_m = w;
        #HALF;
        sclk_in = 1'b1;
        #HALF;
    endtask

    task automatic slot(input logic w, input int n);
        for (int i = 0; i < n; i++) fall_edge(w);
    endtask

    task automatic align();
        @(negedge mclk);
        #2;
    endtask

    task automatic push(input logic [W-1:0] l, input logic [W-1:0] r, output time t);
        bit done;
        done = 1'b0;
        t    = 0;
        @(negedge mclk);
        tx_data_l = l;
        tx_data_r = r;
        tx_valid  = 1'b1;
        for (int i = 0; i < 4000 && !done; i++) begin
            if (tx_ready === 1'b1) begin
                @(posedge mclk);
                done = 1'b1;
                t    = $time;
                exp_q.push_back('{l: l, r: r, t: $time});
            end else begin
                @(negedge mclk);
            end
        end
        #1;
        tx_valid = 1'b0;
        check($sformatf("push_%0h_accepted", l), 64'(done), 64'd1);
    endtask

    initial begin
        time t_acc, t2;

        repeat (3) @(posedge mclk);
        #1;
        check("rst_sd_tx", 64'(sd_tx), 64'd0);
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_underrun", 64'(underrun), 64'd0);
        check("rst_tx_ready", 64'(tx_ready), 64'd1);
        @(negedge mclk);
        rst = 1'b0;

        // Pair before lock, emitted in the first locked frame.
        push(8'hA5, 8'h3C, t_acc);
        check("ready_low_when_full", 64'(tx_ready), 64'd0);
        align();
        slot(1'b1, 32); slot(1'b0, 32); slot(1'b1, 32);

        // Starved frames: zeros and one underrun per left boundary.
        slot(1'b0, 32); slot(1'b1, 32); slot(1'b0, 32); slot(1'b1, 32);
        check("underrun_starved", 64'(urun_seen), 64'd2);

        // Second pair waits for the move cycle of the next left boundary.
        push(8'h11, 8'h22, t_acc);
        left_t.delete();
        fork
            push(8'h33, 8'h44, t2);
            begin
                align();
                slot(1'b0, 32); slot(1'b1, 32); slot(1'b0, 32); slot(1'b1, 32);
            end
        join
        check("accept_in_move_cycle", 64'(t2 > left_t[0] && t2 <= left_t[0] + 40), 64'd1);
        check("underrun_back_to_back", 64'(urun_seen), 64'd2);

        // Truncated 6-bit left slot.
        push(8'hFF, 8'h81, t_acc);
        align();
        slot(1'b0, 6); slot(1'b1, 32); slot(1'b0, 32); slot(1'b1, 32);
        check("underrun_after_trunc", 64'(urun_seen), 64'd3);

        // Reset during bit 4 of a left slot carrying 0xFF.
        push(8'hFF, 8'h00, t_acc);
        align();
        slot(1'b0, 5);
        check("bit4_before_rst", 64'(sd_tx), 64'd1);
        close_slot("partial_before_rst");
        @(negedge mclk);
        rst = 1'b1;
        @(posedge mclk);
        #1;
        check("mid_rst_sd_tx", 64'(sd_tx), 64'd0);
        check("mid_rst_locked", 64'(locked), 64'd0);
        check("mid_rst_tx_ready", 64'(tx_ready), 64'd1);
        @(negedge mclk);
        rst = 1'b0;
        st_m = 0; lock_m = 1'b0; ws_prev_m = 1'b0; close_pending = 1'b0;
        cur_word = '0; next_word = '0; act_r_m = '0;
        cap_vec = '0; cap_cnt = 0;
        exp_q.delete();
        align();
        slot(1'b0, 10); slot(1'b1, 32);
        check("no_lock_on_rising_ws", 64'(locked), 64'd0);
        slot(1'b0, 32); slot(1'b1, 32); slot(1'b0, 2);
        check("underrun_after_relock", 64'(urun_seen), 64'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2s_target_transmitter.md
I2S_TARGET_TRANSMITTER -- requirements
Module: i2s_target_transmitter

Interface
REQ-001 Parameter WIDTH, default 8, sample word width in bits; legal range 8..32.
REQ-002 mclk  input  1  sole clock; every flop is clocked on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset, sampled on rising mclk.
REQ-004 sclk_in  input  1  external I2S bit clock, asynchronous to mclk; mclk SHALL be at least 6x sclk_in.
REQ-005 ws_in  input  1  external word select, asynchronous; 0 = left slot, 1 = right slot.
REQ-006 tx_data_l  input  WIDTH  left sample offered with tx_valid.
REQ-007 tx_data_r  input  WIDTH  right sample offered with tx_valid.
REQ-008 tx_valid  input  1  stereo pair offered.
REQ-009 tx_ready  output  1  block can accept a pair this cycle.
REQ-010 sd_tx  output  1  serial data, MSB first.
REQ-011 locked  output  1  high once frame alignment has been acquired.
REQ-012 underrun  output  1  one-cycle pulse when a left slot starts with no pair buffered.

Function
REQ-013 sclk_in and ws_in SHALL each pass through a 2-flop synchronizer; edges are detected against a third register, so detection latency is 3 mclk.
REQ-014 ws SHALL be sampled only on detected sclk falling edges; a slot boundary is a sampled ws differing from the ws sampled at the previous falling edge.
REQ-015 Philips timing: the MSB of a slot SHALL be driven on the sclk falling edge after the one that detected the boundary.
REQ-016 sd_tx SHALL update in the mclk cycle after a detected falling edge and SHALL hold between falling edges.
REQ-017 In each slot, bits WIDTH-1..0 are sent, followed by zeros until the next boundary; a boundary arriving early truncates the word with no error.
REQ-018 FSM states: UNLOCKED, LEFT, RIGHT.
REQ-019 UNLOCKED -> LEFT on a 1->0 ws boundary; LEFT -> RIGHT on a 0->1 boundary; RIGHT -> LEFT on a 1->0 boundary.
REQ-020 A boundary of the wrong polarity in LEFT or RIGHT SHALL be treated as the correct next slot; no relock occurs.
REQ-021 While UNLOCKED, sd_tx = 0 and locked = 0; locked SHALL assert in the cycle the FSM enters LEFT.
REQ-022 Buffering: one holding register (pair plus full flag) and one active register (pair being shifted).
REQ-023 tx_ready = !full; a pair transfers on tx_valid && tx_ready and sets full.
REQ-024 At each left-slot boundary: if full, holding moves to active and full clears; otherwise active loads 0/0 and underrun pulses.
REQ-025 If tx_valid and a left-slot boundary coincide while full, the move and the new accept both occur that cycle; no data is lost or duplicated.
REQ-026 The right word SHALL come from the same active pair as the preceding left word.
REQ-027 No pairs are consumed while UNLOCKED, so no underrun pulses before lock.

Reset
REQ-028 On rst: sd_tx = 0, locked = 0, underrun = 0, tx_ready = 1, full = 0, active = 0, FSM = UNLOCKED, synchronizers = 0.
REQ-029 rst asserted mid-slot SHALL abort the word; after release the block relocks at the next 1->0 ws boundary.

Structure
REQ-030 Package i2s_pkg SHALL hold the FSM state enum and the WIDTH default, shared with the existing I2S receiver and transmitter.
REQ-031 Sub-module sync_edge_detect (2-flop synchronizer, rise/fall pulses) SHALL be instantiated twice, for sclk_in and ws_in.

Verification
REQ-032 WIDTH=8, mclk 22.579 MHz, sclk 2.822 MHz, 32 bits/slot; push pair L=0xA5, R=0x3C -> after lock, left slot bits 10100101 then 24 zeros, right slot 00111100 then zeros, MSB one sclk after the boundary.
REQ-033 No pair pushed after lock -> underrun pulses once per left boundary and both slots are all zeros.
REQ-034 Push 0x11/0x22, then 0x33/0x44 while full -> tx_ready low until the next left boundary; the second pair is accepted in the move cycle and the frames emit in order.
REQ-035 Assert rst at bit 4 of the left slot carrying 0xFF -> sd_tx = 0 next mclk; after release, locked stays low until the next 1->0 ws edge.
REQ-036 Slot of 6 sclk with WIDTH=8 and L=0xFF -> exactly 6 ones are sent, the right slot starts correctly, and locked stays high.
